// File: rtl/edge_scan_ctrl.sv
// Readout sequencer for the sticky edge-result accumulator: sweeps bank/word selects,
// streams each word on valid/ready tagged with its index, optionally clears the accumulator.
module edge_scan_ctrl #(
    parameter int NUM_BANKS      = 8,
    parameter int WORDS_PER_BANK = 16,
    parameter int CLR_CYCLES     = 2
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    input  logic        abort,
    input  logic        skip_zero,
    input  logic        auto_clear,
    output logic [2:0]  sel1,
    output logic [7:0]  sel2,
    input  logic [31:0] result_imp,
    output logic        acc_rst_n,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [6:0]  m_index,
    output logic        busy,
    output logic        done,
    output logic [7:0]  nz_count
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, CLEAR, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    bank_q, bank_d;
    logic [3:0]    word_q, word_d;
    logic          m_valid_d, acc_rst_n_d;
    logic [31:0]   m_data_d;
    logic [6:0]    m_index_d;
    logic [7:0]    nz_d;
    logic          skip_l, skip_d, aclr_l, aclr_d;
    logic [CW-1:0] clr_cnt, clr_cnt_d;
    logic          capture, last_word, word_zero;

    // The bank/word counters are the select registers themselves.
    assign sel1      = bank_q;
    assign sel2      = {4'b0000, word_q};
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign capture   = !m_valid || m_ready;
    assign word_zero = (result_imp == 32'd0);
    assign last_word = (bank_q == 3'(NUM_BANKS - 1)) && (word_q == 4'(WORDS_PER_BANK - 1));

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        word_d      = word_q;
        m_valid_d   = m_valid;
        m_data_d    = m_data;
        m_index_d   = m_index;
        nz_d        = nz_count;
        acc_rst_n_d = acc_rst_n;
        skip_d      = skip_l;
        aclr_d      = aclr_l;
        clr_cnt_d   = clr_cnt;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    skip_d  = skip_zero;
                    aclr_d  = auto_clear;
                    bank_d  = '0;
                    word_d  = '0;
                    nz_d    = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (capture) begin
                    if (!word_zero) nz_d = nz_count + 8'd1;
                    if (!(skip_l && word_zero)) begin
                        m_data_d  = result_imp;
                        m_index_d = {bank_q, word_q};
                        m_valid_d = 1'b1;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                    if (last_word) begin
                        bank_d  = '0;
                        word_d  = '0;
                        state_d = DRAIN;
                    end else if (word_q == 4'(WORDS_PER_BANK - 1)) begin
                        word_d = '0;
                        bank_d = bank_q + 3'd1;
                    end else begin
                        word_d = word_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (capture) begin
                    m_valid_d = 1'b0;
                    if (aclr_l) begin
                        acc_rst_n_d = 1'b0;
                        clr_cnt_d   = '0;
                        state_d     = CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                    acc_rst_n_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    clr_cnt_d = clr_cnt + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything in flight; nz_count keeps the partial tally.
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            m_valid_d   = 1'b0;
            m_data_d    = m_data;
            m_index_d   = m_index;
            nz_d        = nz_count;
            acc_rst_n_d = 1'b1;
            bank_d      = '0;
            word_d      = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            word_q    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            nz_count  <= '0;
            acc_rst_n <= 1'b1;
            skip_l    <= 1'b0;
            aclr_l    <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            word_q    <= word_d;
            m_valid   <= m_valid_d;
            m_data    <= m_data_d;
            m_index   <= m_index_d;
            nz_count  <= nz_d;
            acc_rst_n <= acc_rst_n_d;
            skip_l    <= skip_d;
            aclr_l    <= aclr_d;
            clr_cnt   <= clr_cnt_d;
        end
    end

endmodule
